// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the digest transmitter state encoding.
package sha256_pkg;

  localparam int unsigned DIGEST_WORDS = 8;
  localparam int unsigned DIGEST_BYTES = 32;

  // SHA-256 initial hash values H0..H7
  localparam logic [31:0] IV_H0 = 32'h6a09e667;
  localparam logic [31:0] IV_H1 = 32'hbb67ae85;
  localparam logic [31:0] IV_H2 = 32'h3c6ef372;
  localparam logic [31:0] IV_H3 = 32'ha54ff53a;
  localparam logic [31:0] IV_H4 = 32'h510e527f;
  localparam logic [31:0] IV_H5 = 32'h9b05688c;
  localparam logic [31:0] IV_H6 = 32'h1f83d9ab;
  localparam logic [31:0] IV_H7 = 32'h5be0cd19;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Returns IV word i; indices beyond H7 wrap so any digest width gets a defined fill
  function automatic logic [31:0] iv_word(input int unsigned i);
    logic [31:0] w;
    case (i % 8)
      0:       w = IV_H0;
      1:       w = IV_H1;
      2:       w = IV_H2;
      3:       w = IV_H3;
      4:       w = IV_H4;
      5:       w = IV_H5;
      6:       w = IV_H6;
      default: w = IV_H7;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/hash_digest_tx.sv
// Captures a finished hash digest and streams it out big-endian, one byte per
// valid/ready transfer, flagging the final byte and any digest dropped while busy.
module hash_digest_tx
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DIGEST_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic [32*NUM_WORDS-1:0] digest,
  output logic                    busy,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last,
  output logic                    overrun
);

  localparam int unsigned NUM_BYTES = 4 * NUM_WORDS;
  localparam int unsigned DIGEST_W  = 32 * NUM_WORDS;
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  // Builds the capture register's reset image from the SHA-256 IV, H0 in the MSBs
  function automatic logic [DIGEST_W-1:0] build_reset_value();
    logic [DIGEST_W-1:0] v;
    v = '0;
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      v[DIGEST_W-1-32*w -: 32] = iv_word(w);
    end
    return v;
  endfunction

  localparam logic [DIGEST_W-1:0] RESET_VALUE = build_reset_value();

  tx_state_e           state;
  tx_state_e           state_next;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic [DIGEST_W-1:0] captured;
  logic                capture;
  logic                drop;
  logic                xfer;
  logic                at_last;
  logic [7:0]          byte_lane [NUM_BYTES];

  // Byte k of the captured digest, counted from the most significant end
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    assign byte_lane[k] = captured[DIGEST_W-1-8*k -: 8];
  end

  assign tx_valid = (state == SEND);
  assign busy     = (state == SEND);
  assign at_last  = tx_valid && (idx == LAST_IDX);
  assign tx_last  = at_last;
  assign xfer     = tx_valid && tx_ready;
  assign tx_data  = tx_valid ? byte_lane[idx] : 8'h00;

  // Next-state logic: accept done when idle or on the final transfer, otherwise drop it
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (done) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (xfer && at_last) begin
          idx_next = '0;
          if (done) begin
            capture = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_next = idx + IDX_W'(1);
          end
          if (done) begin
            drop = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // State and byte index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Digest capture register, loaded only on an accepted done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured <= RESET_VALUE;
    end else if (capture) begin
      captured <= digest;
    end
  end

  // Sticky record of any done pulse that arrived while a digest was in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: doc/hash_digest_tx.md
HASH_DIGEST_TX -- requirements
Module: hash_digest_tx

Interface
REQ-001 Parameter NUM_WORDS, default 8, number of 32-bit hash words per digest (SHA-256 H0..H7).
REQ-002 The block SHALL use one clock and asynchronous active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 done  in  1  single-cycle pulse: digest on `digest` is final and valid this cycle.
REQ-006 digest  in  32*NUM_WORDS  concatenated hash words; H0 in the MSBs ([255:224] for the default), H(NUM_WORDS-1) in the LSBs.
REQ-007 busy  out  1  high while a captured digest is still being transmitted.
REQ-008 tx_data  out  8  current digest byte.
REQ-009 tx_valid  out  1  tx_data is valid.
REQ-010 tx_ready  in  1  sink accepts the byte; a transfer occurs on a clock edge where tx_valid and tx_ready are both high.
REQ-011 tx_last  out  1  high with the final byte of a digest.
REQ-012 overrun  out  1  sticky flag: a done pulse was dropped.

Function
REQ-013 The block SHALL have two states, IDLE and SEND; after reset it is in IDLE.
REQ-014 In IDLE, a done pulse SHALL capture `digest` into an internal 32*NUM_WORDS-bit register, clear the byte index to 0, and enter SEND on the same edge.
REQ-015 tx_valid SHALL rise the cycle after done (1-cycle latency); busy SHALL equal (state == SEND).
REQ-016 Byte order SHALL be big-endian: byte k = captured bits [32*NUM_WORDS-1-8k -: 8], so H0[31:24] is sent first.
REQ-017 The byte index SHALL advance by one only on a transfer; tx_data and tx_valid SHALL stay stable while tx_ready is low.
REQ-018 tx_last SHALL be high exactly when tx_valid is high and index == 4*NUM_WORDS-1.
REQ-019 A transfer with tx_last high SHALL return the block to IDLE, deassert tx_valid, and wrap the index to 0.
REQ-020 If done coincides with the tx_last transfer, the block SHALL capture the new digest and stay in SEND with index 0, giving back-to-back digests with no idle gap.
REQ-021 If done arrives in SEND, except in the case covered by REQ-020, the block SHALL ignore it, leave the captured data unchanged, and set overrun.
REQ-022 overrun SHALL clear only on reset.
REQ-023 tx_data SHALL be 8'h00 whenever tx_valid is low.
REQ-024 The captured register SHALL change only on an accepted done.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, index 0, tx_valid 0, tx_last 0, busy 0, tx_data 8'h00 and overrun 0.
REQ-026 The capture register SHALL reset to the SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
REQ-027 Reset during SEND SHALL abort the digest; no partial bytes SHALL appear after rst deasserts.
REQ-028 A done pulse on the first edge after reset release SHALL be accepted normally.

Structure
REQ-029 A shared package sha256_pkg SHALL hold the eight IV constants, DIGEST_WORDS=8, DIGEST_BYTES=32, and the state enumeration (IDLE, SEND).
REQ-030 The block SHALL contain no sub-modules; the byte-select mux, counter and FSM live in one module.
REQ-031 The index width SHALL be clog2(4*NUM_WORDS) bits (5 for the default).

Verification
REQ-032 Single digest: after reset, pulse done with digest = IV and hold tx_ready high -> 32 consecutive bytes starting 6a 09 e6 67 bb … and ending … 5b e0 cd 19; tx_last on byte 32; busy low the next cycle.
REQ-033 Backpressure: toggle tx_ready randomly during a digest -> the same byte sequence, and tx_data is stable on every cycle where valid is high and ready is low.
REQ-034 Overrun: pulse done again at byte 10 with digest = all 0xFF -> the stream finishes the first digest unchanged, and overrun=1 stays set until rst.
REQ-035 Back-to-back: pulse done with digest = all 0xA5 on the tx_last transfer cycle -> the next cycle shows tx_valid=1 and tx_data=a5, index 0, with no gap.
REQ-036 Reset mid-stream: assert rst at byte 17 -> outputs go to 0 immediately; after release, with no done, tx_valid stays 0 for 50 cycles.
REQ-037 Parameter check: NUM_WORDS=1 with digest=32'h3c6ef372 -> bytes 3c 6e f3 72, with tx_last on the 4th byte.
